// File: rtl/memory_burst_bridge.sv
// Word-to-byte burst bridge between a bus master and a byte-serial PSRAM controller.
// Optional macro MEMBRIDGE_BYTESWAP_EN selects little-endian byte order in both directions.
module memory_burst_bridge #(
    parameter int ADDR_WIDTH  = 22,
    parameter int WORD_BYTES  = 4,
    parameter int BURST_WIDTH = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [ADDR_WIDTH-1:0]                    a,
    input  logic [BURST_WIDTH-1:0]                   burst_len,
    input  logic                                     rd,
    input  logic                                     we,
    input  logic [8*WORD_BYTES-1:0]                  d,
    output logic [8*WORD_BYTES-1:0]                  spo,
    output logic                                     rvalid,
    output logic                                     wnext,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     m_rd,
    output logic                                     m_we,
    output logic                                     m_rend,
    output logic                                     m_wend,
    output logic [ADDR_WIDTH+$clog2(WORD_BYTES)-1:0] m_a,
    output logic [7:0]                               m_din,
    input  logic [7:0]                               m_dout,
    input  logic                                     m_byte_available,
    input  logic                                     m_ready_for_next_byte,
    input  logic                                     m_ready
);

    localparam int WORD_W     = 8 * WORD_BYTES;
    localparam int BYTE_SHIFT = $clog2(WORD_BYTES);
    localparam int MA_W       = ADDR_WIDTH + BYTE_SHIFT;
    localparam int IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'((WORD_BYTES > 1) ? WORD_BYTES - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_START, S_RD_BYTE, S_RD_WORD, S_WR_START, S_WR_BYTE, S_WR_LOAD
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_a;
    logic [BURST_WIDTH-1:0] r_words;
    logic [IDX_W-1:0]       r_idx;
    logic [WORD_W-1:0]      r_rbuf;
    logic [WORD_W-1:0]      r_wbuf;
    logic [WORD_W-1:0]      r_spo;
    logic                   r_ba_old;
    logic                   r_rn_old;
    logic                   r_rvalid, r_wnext, r_busy, r_done;
    logic                   r_m_rd, r_m_we, r_m_rend, r_m_wend;

    logic [IDX_W-1:0]       w_pos;
    logic [WORD_W-1:0]      w_rbuf_next;
    logic [7:0]             w_din;
    logic                   w_ba_rise;
    logic                   w_rn_rise;
    logic                   w_last_word;
    logic                   w_last_byte;

    assign w_ba_rise   = m_byte_available & ~r_ba_old;
    assign w_rn_rise   = m_ready_for_next_byte & ~r_rn_old;
    assign w_last_word = (r_words == '0);
    assign w_last_byte = (r_idx == LAST_IDX);

    // Byte index counts transfers; w_pos maps it onto a lane of the word.
    always_comb begin
`ifdef MEMBRIDGE_BYTESWAP_EN
        w_pos = r_idx;
`else
        w_pos = LAST_IDX - r_idx;
`endif
        w_rbuf_next = r_rbuf;
        w_rbuf_next[8*w_pos +: 8] = m_dout;
        w_din = r_wbuf[8*w_pos +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the word buffers are cleared too, so spo and m_din read 0 out of reset.
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_words  <= '0;
            r_idx    <= '0;
            r_rbuf   <= '0;
            r_wbuf   <= '0;
            r_spo    <= '0;
            r_ba_old <= 1'b0;
            r_rn_old <= 1'b0;
            r_rvalid <= 1'b0;
            r_wnext  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_m_rd   <= 1'b0;
            r_m_we   <= 1'b0;
            r_m_rend <= 1'b0;
            r_m_wend <= 1'b0;
        end else begin
            r_ba_old <= m_byte_available;
            r_rn_old <= m_ready_for_next_byte;
            // NOTE: pulse outputs default low here; a later non-blocking write in the case wins.
            r_m_rd   <= 1'b0;
            r_m_we   <= 1'b0;
            r_rvalid <= 1'b0;
            r_wnext  <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (we || rd) begin
                        r_a      <= a;
                        r_words  <= burst_len;
                        r_idx    <= '0;
                        r_m_rend <= 1'b0;
                        r_m_wend <= 1'b0;
                        r_busy   <= 1'b1;
                        if (we) begin
                            r_wbuf  <= d;
                            r_state <= S_WR_START;
                        end else begin
                            r_state <= S_RD_START;
                        end
                    end
                end
                S_RD_START: begin
                    if (m_ready) begin
                        r_m_rd  <= 1'b1;
                        r_state <= S_RD_BYTE;
                    end
                end
                S_RD_BYTE: begin
                    if (WORD_BYTES == 1 && w_last_word) r_m_rend <= 1'b1;
                    if (w_ba_rise) begin
                        r_rbuf <= w_rbuf_next;
                        r_idx  <= r_idx + 1'b1;
                        // End-of-stream goes out one byte early so the controller stops cleanly.
                        if (WORD_BYTES > 1 && w_last_word && r_idx == PEN_IDX) r_m_rend <= 1'b1;
                        if (w_last_byte) begin
                            r_spo    <= w_rbuf_next;
                            r_rvalid <= 1'b1;
                            r_done   <= w_last_word;
                            r_state  <= S_RD_WORD;
                        end
                    end
                end
                S_RD_WORD: begin
                    if (w_last_word) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_words <= r_words - 1'b1;
                        r_idx   <= '0;
                        r_state <= S_RD_BYTE;
                    end
                end
                S_WR_START: begin
                    if (m_ready) begin
                        r_m_we  <= 1'b1;
                        r_state <= S_WR_BYTE;
                    end
                end
                S_WR_BYTE: begin
                    if (w_rn_rise) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last_byte) begin
                            if (w_last_word) begin
                                r_m_wend <= 1'b1;
                                r_done   <= 1'b1;
                                r_busy   <= 1'b0;
                                r_state  <= S_IDLE;
                            end else begin
                                r_wnext <= 1'b1;
                                r_state <= S_WR_LOAD;
                            end
                        end
                    end
                end
                S_WR_LOAD: begin
                    r_wbuf  <= d;
                    r_words <= r_words - 1'b1;
                    r_idx   <= '0;
                    r_state <= S_WR_BYTE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign spo    = r_spo;
    assign rvalid = r_rvalid;
    assign wnext  = r_wnext;
    assign busy   = r_busy;
    assign done   = r_done;
    assign m_rd   = r_m_rd;
    assign m_we   = r_m_we;
    assign m_rend = r_m_rend;
    assign m_wend = r_m_wend;
    assign m_a    = MA_W'(r_a) << BYTE_SHIFT;
    assign m_din  = w_din;

endmodule
